// File: rtl/prf_busy_table_pkg.sv
// Shared widths for the rename/issue slice: physical register file,
// dispatch and writeback bundle sizes.
package prf_busy_table_pkg;

    localparam int PRF_WIDTH  = 6;
    localparam int NUM_PRF    = 2 ** PRF_WIDTH;
    localparam int DISP_WIDTH = 4;
    localparam int WB_WIDTH   = 4;
    localparam int CNT_WIDTH  = PRF_WIDTH + 1;

    typedef logic [PRF_WIDTH-1:0] preg_t;

    function automatic logic [CNT_WIDTH-1:0] busy_popcnt(
        input logic [NUM_PRF-1:0] rdy
    );
        logic [CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int n = 0; n < NUM_PRF; n++) begin
            cnt = cnt + CNT_WIDTH'(~rdy[n]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prf_busy_table_src_rdy.sv
// Combinational ready resolver for one source operand of one dispatch slot:
// table bit, writeback bypass and older-slot dependency in the same bundle.
module prf_src_rdy_lookup
    import prf_busy_table_pkg::*;
#(
    parameter int SLOT = 0
) (
    input  logic                          i_prs_v,
    input  logic [PRF_WIDTH-1:0]          i_prs,
    input  logic [NUM_PRF-1:0]            i_rdy,
    input  logic [WB_WIDTH-1:0]           i_wb_valid,
    input  logic [WB_WIDTH*PRF_WIDTH-1:0] i_wb_prd,
    input  logic [DISP_WIDTH-1:0]         i_disp_valid,
    input  logic [DISP_WIDTH-1:0]         i_disp_prd_v,
    input  logic [DISP_WIDTH*PRF_WIDTH-1:0] i_disp_prd,
    output logic                          o_rdy
);

    logic w_bypass;
    logic w_dep;
    logic w_zero;

    always_comb begin
        w_bypass = 1'b0;
        w_dep    = 1'b0;
        w_zero   = (i_prs == '0);
        for (int j = 0; j < WB_WIDTH; j++) begin
            if (i_wb_valid[j] && i_wb_prd[j*PRF_WIDTH +: PRF_WIDTH] == i_prs)
                w_bypass = 1'b1;
        end
        // Only older slots in the bundle can be producers of this source.
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (k < SLOT && i_disp_valid[k] && i_disp_prd_v[k] &&
                i_disp_prd[k*PRF_WIDTH +: PRF_WIDTH] == i_prs && !w_zero)
                w_dep = 1'b1;
        end
        o_rdy = !i_prs_v || w_zero || (!w_dep && (w_bypass || i_rdy[i_prs]));
    end

endmodule

// File: rtl/prf_busy_table.sv
// Physical-register ready table feeding per-source ready bits to the
// issue queue; cleared on dispatch allocation, set on writeback.
module prf_busy_table
    import prf_busy_table_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            disp_fire,
    input  logic [DISP_WIDTH-1:0]           disp_valid,
    input  logic [DISP_WIDTH-1:0]           disp_prs1_v,
    input  logic [DISP_WIDTH-1:0]           disp_prs2_v,
    input  logic [DISP_WIDTH-1:0]           disp_prd_v,
    input  logic [DISP_WIDTH*PRF_WIDTH-1:0] disp_prs1,
    input  logic [DISP_WIDTH*PRF_WIDTH-1:0] disp_prs2,
    input  logic [DISP_WIDTH*PRF_WIDTH-1:0] disp_prd,
    input  logic [WB_WIDTH-1:0]             wb_valid,
    input  logic [WB_WIDTH*PRF_WIDTH-1:0]   wb_prd,
    output logic [DISP_WIDTH-1:0]           disp_prs1_rdy,
    output logic [DISP_WIDTH-1:0]           disp_prs2_rdy,
    output logic [PRF_WIDTH:0]              busy_cnt
);

    logic [NUM_PRF-1:0]   r_rdy;
    logic [CNT_WIDTH-1:0] r_busy_cnt;
    logic [NUM_PRF-1:0]   w_rdy_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    for (genvar i = 0; i < DISP_WIDTH; i++) begin : g_slot
        prf_src_rdy_lookup #(.SLOT(i)) u_rs1 (
            .i_prs_v      (disp_prs1_v[i]),
            .i_prs        (disp_prs1[i*PRF_WIDTH +: PRF_WIDTH]),
            .i_rdy        (r_rdy),
            .i_wb_valid   (wb_valid),
            .i_wb_prd     (wb_prd),
            .i_disp_valid (disp_valid),
            .i_disp_prd_v (disp_prd_v),
            .i_disp_prd   (disp_prd),
            .o_rdy        (disp_prs1_rdy[i])
        );
        prf_src_rdy_lookup #(.SLOT(i)) u_rs2 (
            .i_prs_v      (disp_prs2_v[i]),
            .i_prs        (disp_prs2[i*PRF_WIDTH +: PRF_WIDTH]),
            .i_rdy        (r_rdy),
            .i_wb_valid   (wb_valid),
            .i_wb_prd     (wb_prd),
            .i_disp_valid (disp_valid),
            .i_disp_prd_v (disp_prd_v),
            .i_disp_prd   (disp_prd),
            .o_rdy        (disp_prs2_rdy[i])
        );
    end

    // Clears are applied after sets so allocation wins a same-cycle race.
    always_comb begin
        w_rdy_nxt = r_rdy;
        for (int j = 0; j < WB_WIDTH; j++) begin
            if (wb_valid[j])
                w_rdy_nxt[wb_prd[j*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
        end
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (disp_fire && disp_valid[i] && disp_prd_v[i] &&
                disp_prd[i*PRF_WIDTH +: PRF_WIDTH] != '0)
                w_rdy_nxt[disp_prd[i*PRF_WIDTH +: PRF_WIDTH]] = 1'b0;
        end
        if (flush)
            w_rdy_nxt = '1;
        w_cnt_nxt = busy_popcnt(w_rdy_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy      <= '1;
            r_busy_cnt <= '0;
        end else begin
            r_rdy      <= w_rdy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_prf_busy_table.sv
// Scenario bench for prf_busy_table: expected lookup/count triples are
// queued when stimulus is driven and popped when outputs are sampled.
module tb_prf_busy_table;
    import prf_busy_table_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            flush;
    logic                            disp_fire;
    logic [DISP_WIDTH-1:0]           disp_valid;
    logic [DISP_WIDTH-1:0]           disp_prs1_v;
    logic [DISP_WIDTH-1:0]           disp_prs2_v;
    logic [DISP_WIDTH-1:0]           disp_prd_v;
    logic [DISP_WIDTH*PRF_WIDTH-1:0] disp_prs1;
    logic [DISP_WIDTH*PRF_WIDTH-1:0] disp_prs2;
    logic [DISP_WIDTH*PRF_WIDTH-1:0] disp_prd;
    logic [WB_WIDTH-1:0]             wb_valid;
    logic [WB_WIDTH*PRF_WIDTH-1:0]   wb_prd;
    logic [DISP_WIDTH-1:0]           disp_prs1_rdy;
    logic [DISP_WIDTH-1:0]           disp_prs2_rdy;
    logic [PRF_WIDTH:0]              busy_cnt;

    typedef struct packed {
        logic [3:0] r1;
        logic [3:0] r2;
        logic [6:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    exp_t got;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    prf_busy_table dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_fire     (disp_fire),
        .disp_valid    (disp_valid),
        .disp_prs1_v   (disp_prs1_v),
        .disp_prs2_v   (disp_prs2_v),
        .disp_prd_v    (disp_prd_v),
        .disp_prs1     (disp_prs1),
        .disp_prs2     (disp_prs2),
        .disp_prd      (disp_prd),
        .wb_valid      (wb_valid),
        .wb_prd        (wb_prd),
        .disp_prs1_rdy (disp_prs1_rdy),
        .disp_prs2_rdy (disp_prs2_rdy),
        .busy_cnt      (busy_cnt)
    );

    task automatic clr_in();
        flush       = 1'b0;
        disp_fire   = 1'b0;
        disp_valid  = '0;
        disp_prs1_v = '0;
        disp_prs2_v = '0;
        disp_prd_v  = '0;
        disp_prs1   = '0;
        disp_prs2   = '0;
        disp_prd    = '0;
        wb_valid    = '0;
        wb_prd      = '0;
    endtask

    task automatic src1(input int s, input int p);
        disp_prs1_v[s] = 1'b1;
        disp_prs1[s*PRF_WIDTH +: PRF_WIDTH] = PRF_WIDTH'(p);
    endtask

    task automatic src2(input int s, input int p);
        disp_prs2_v[s] = 1'b1;
        disp_prs2[s*PRF_WIDTH +: PRF_WIDTH] = PRF_WIDTH'(p);
    endtask

    task automatic dst(input int s, input int p);
        disp_valid[s] = 1'b1;
        disp_prd_v[s] = 1'b1;
        disp_prd[s*PRF_WIDTH +: PRF_WIDTH] = PRF_WIDTH'(p);
    endtask

    task automatic wb(input int j, input int p);
        wb_valid[j] = 1'b1;
        wb_prd[j*PRF_WIDTH +: PRF_WIDTH] = PRF_WIDTH'(p);
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr_in();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < NUM_PRF; b += 4) begin
            for (int s = 0; s < 4; s++) begin
                src1(s, b + s);
                src2(s, 63 - b - s);
            end
            exp_q.push_back('{r1: 4'hF, r2: 4'hF, cnt: 7'd0});
            #1;
            got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_lookup base=%0d got=%h exp=%h", b, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wb_bypass();
        clr_in();
        disp_fire = 1'b1;
        dst(0, 10);
        @(negedge clk);
        clr_in();
        src1(1, 10);
        exp_q.push_back('{r1: 4'b1101, r2: 4'hF, cnt: 7'd1});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL wb_busy got=%h exp=%h", got, e);
        end
        @(negedge clk);
        wb(2, 10);
        exp_q.push_back('{r1: 4'hF, r2: 4'hF, cnt: 7'd1});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL wb_bypass got=%h exp=%h", got, e);
        end
        @(negedge clk);
        clr_in();
        src1(1, 10);
        exp_q.push_back('{r1: 4'hF, r2: 4'hF, cnt: 7'd0});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL wb_table got=%h exp=%h", got, e);
        end
        @(negedge clk);
    endtask

    task automatic test_intra_group();
        clr_in();
        dst(0, 12);
        src1(2, 12);
        src2(1, 12);
        src1(0, 12);
        exp_q.push_back('{r1: 4'b1011, r2: 4'b1101, cnt: 7'd0});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL intra_dep got=%h exp=%h", got, e);
        end
        @(negedge clk);
        clr_in();
        dst(0, 0);
        src1(1, 0);
        disp_prd_v[2] = 1'b1;
        disp_prd[2*PRF_WIDTH +: PRF_WIDTH] = 6'd12;
        src2(3, 12);
        exp_q.push_back('{r1: 4'hF, r2: 4'hF, cnt: 7'd0});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL intra_nodep got=%h exp=%h", got, e);
        end
        @(negedge clk);
        clr_in();
        dst(1, 15);
        wb(0, 15);
        src1(3, 15);
        exp_q.push_back('{r1: 4'b0111, r2: 4'hF, cnt: 7'd0});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL intra_over_wb got=%h exp=%h", got, e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        clr_in();
        disp_fire = 1'b1;
        for (int s = 0; s < 4; s++) dst(s, 40 + s);
        @(negedge clk);
        clr_in();
        disp_fire = 1'b1;
        dst(0, 44);
        wb(0, 40);
        wb(1, 40);
        wb(2, 41);
        wb(3, 41);
        src1(1, 40);
        src1(2, 42);
        exp_q.push_back('{r1: 4'b1011, r2: 4'hF, cnt: 7'd4});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL b2b_dup_wb got=%h exp=%h", got, e);
        end
        @(negedge clk);
        clr_in();
        for (int s = 0; s < 4; s++) src1(s, 40 + s);
        src2(0, 44);
        exp_q.push_back('{r1: 4'b0011, r2: 4'b1110, cnt: 7'd3});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL b2b_state got=%h exp=%h", got, e);
        end
        wb(0, 42);
        wb(1, 43);
        wb(2, 44);
        @(negedge clk);
        clr_in();
        src1(2, 42);
        src1(3, 43);
        src2(0, 44);
        exp_q.push_back('{r1: 4'hF, r2: 4'hF, cnt: 7'd0});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL b2b_drain got=%h exp=%h", got, e);
        end
        @(negedge clk);
    endtask

    task automatic test_clear_wins();
        clr_in();
        disp_fire = 1'b1;
        dst(0, 20);
        dst(1, 0);
        wb(0, 20);
        @(negedge clk);
        clr_in();
        src1(0, 20);
        src1(1, 0);
        exp_q.push_back('{r1: 4'b1110, r2: 4'hF, cnt: 7'd1});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL clear_wins got=%h exp=%h", got, e);
        end
        @(negedge clk);
    endtask

    task automatic test_no_fire();
        clr_in();
        for (int s = 0; s < 4; s++) dst(s, 30 + s);
        @(negedge clk);
        clr_in();
        for (int s = 0; s < 4; s++) src1(s, 30 + s);
        src2(0, 20);
        exp_q.push_back('{r1: 4'hF, r2: 4'b1110, cnt: 7'd1});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL no_fire got=%h exp=%h", got, e);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        clr_in();
        disp_fire = 1'b1;
        dst(0, 5);
        dst(1, 6);
        dst(2, 7);
        @(negedge clk);
        clr_in();
        src1(0, 5);
        src1(1, 6);
        src1(2, 7);
        exp_q.push_back('{r1: 4'b1000, r2: 4'hF, cnt: 7'd4});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL pre_flush got=%h exp=%h", got, e);
        end
        @(negedge clk);
        clr_in();
        flush = 1'b1;
        disp_fire = 1'b1;
        dst(0, 8);
        @(negedge clk);
        clr_in();
        for (int s = 0; s < 4; s++) src1(s, 5 + s);
        src2(0, 20);
        exp_q.push_back('{r1: 4'hF, r2: 4'hF, cnt: 7'd0});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL post_flush got=%h exp=%h", got, e);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_flush();
        clr_in();
        disp_fire = 1'b1;
        dst(0, 9);
        @(negedge clk);
        clr_in();
        src1(0, 9);
        exp_q.push_back('{r1: 4'b1110, r2: 4'hF, cnt: 7'd1});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL pre_rst got=%h exp=%h", got, e);
        end
        @(negedge clk);
        clr_in();
        rst = 1'b1;
        flush = 1'b1;
        disp_fire = 1'b1;
        dst(0, 11);
        @(negedge clk);
        clr_in();
        rst = 1'b0;
        src1(0, 9);
        src1(1, 11);
        exp_q.push_back('{r1: 4'hF, r2: 4'hF, cnt: 7'd0});
        #1;
        got = '{disp_prs1_rdy, disp_prs2_rdy, busy_cnt};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL rst_flush got=%h exp=%h", got, e);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        test_reset();
        test_wb_bypass();
        test_intra_group();
        test_back_to_back();
        test_clear_wins();
        test_no_fire();
        test_flush();
        test_rst_flush();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
